// File: rtl/m68k_bus_target.sv
// Responder for the 68000-style asynchronous bus. It turns AS/UDS/LDS/RW/FC cycles into single-outstanding
// backend requests and answers with DTACK, VPA (6800 peripherals), IACK vectors or BERR.
module m68k_bus_target #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned BERR_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi1,
  input  logic        phi2,
  input  logic        as_n,
  input  logic        rw_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic [2:0]  fc,
  input  logic [22:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr,
  input  logic        vma_n,
  input  logic        e_negclken,
  input  logic        periph_sel,
  input  logic        iack_auto,
  input  logic [7:0]  iack_vector,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [3:0] WS  = 4'(WAIT_STATES);
  localparam logic [8:0] TMO = 9'(BERR_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_MEM_WAIT, S_DELAY, S_ACK, S_VPA_WAIT, S_VPA_E, S_IACK, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic        rw_q, rw_d;
  logic [2:0]  fc_q, fc_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [15:0] rdata_q, rdata_d;
  logic        dtack_n_q, dtack_n_d;
  logic        vpa_n_q, vpa_n_d;
  logic        berr_q, berr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  wait_q, wait_d;
  logic        req_sent_q, req_sent_d;
  logic        tmo_run;

  // phi1 and the E falling edge are only timing references for the CPU side.
  logic unused_inputs;
  assign unused_inputs = ^{phi1, e_negclken};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    rw_d        = rw_q;
    fc_d        = fc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    rdata_d     = rdata_q;
    dtack_n_d   = dtack_n_q;
    vpa_n_d     = vpa_n_q;
    berr_d      = berr_q;
    tmo_d       = tmo_q;
    wait_d      = wait_q;
    req_sent_d  = req_sent_q;
    tmo_run     = 1'b0;

    if (state_q == S_IDLE) begin
      if (!as_n) begin
        state_d    = S_START;
        mem_addr_d = addr;
        fc_d       = fc;
        rw_d       = rw_n;
        tmo_d      = '0;
        wait_d     = '0;
        req_sent_d = 1'b0;
      end
    end else if (as_n) begin
      // Normal end of cycle and early abort share one path back to idle.
      state_d   = S_IDLE;
      dtack_n_d = 1'b1;
      vpa_n_d   = 1'b1;
      berr_d    = 1'b0;
      mem_we_d  = 1'b0;
      mem_be_d  = 2'b00;
      tmo_d     = '0;
    end else begin
      case (state_q)
        S_START: begin
          tmo_run = 1'b1;
          if (rw_q || !uds_n || !lds_n) begin
            if (fc_q == 3'b111) begin
              state_d = S_IACK;
            end else if (periph_sel) begin
              state_d = S_VPA_WAIT;
            end else begin
              state_d     = S_MEM_WAIT;
              mem_req_d   = 1'b1;
              mem_we_d    = ~rw_q;
              mem_be_d    = {~uds_n, ~lds_n};
              mem_wdata_d = wdata;
            end
          end
        end
        S_MEM_WAIT: begin
          tmo_run = 1'b1;
          if (mem_ack) begin
            if (rw_q) rdata_d = mem_rdata;
            wait_d  = '0;
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          tmo_run = 1'b1;
          if (WS == 4'd0) begin
            state_d = S_ACK;
          end else if (phi2) begin
            if (wait_q == WS - 4'd1) state_d = S_ACK;
            else                     wait_d  = wait_q + 4'd1;
          end
        end
        S_ACK: begin
          if (phi2) dtack_n_d = 1'b0;
        end
        S_IACK: begin
          if (dtack_n_q && vpa_n_q) begin
            tmo_run = 1'b1;
            if (iack_auto) begin
              vpa_n_d = 1'b0;
            end else begin
              rdata_d = {8'h00, iack_vector};
              if (phi2) dtack_n_d = 1'b0;
            end
          end
        end
        S_VPA_WAIT: begin
          tmo_run = 1'b1;
          if (phi2) vpa_n_d = 1'b0;
          if (!req_sent_q) begin
            if (!vma_n) begin
              mem_req_d   = 1'b1;
              mem_we_d    = ~rw_q;
              mem_be_d    = {~uds_n, ~lds_n};
              mem_wdata_d = wdata;
              req_sent_d  = 1'b1;
            end
          end else if (mem_ack) begin
            if (rw_q) rdata_d = mem_rdata;
            vpa_n_d = 1'b0;
            state_d = S_VPA_E;
          end
        end
        S_VPA_E: vpa_n_d = 1'b0;
        S_ERR:   berr_d  = 1'b1;
        default: state_d = S_IDLE;
      endcase

      if (tmo_run) begin
        tmo_d = tmo_q + 8'd1;
        if ({1'b0, tmo_q} + 9'd1 == TMO) begin
          state_d   = S_ERR;
          berr_d    = 1'b1;
          mem_req_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b1;
      fc_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 2'b00;
      rdata_q    <= '0;
      dtack_n_q  <= 1'b1;
      vpa_n_q    <= 1'b1;
      berr_q     <= 1'b0;
      tmo_q      <= '0;
      wait_q     <= '0;
      req_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      fc_q       <= fc_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_be_q   <= mem_be_d;
      rdata_q    <= rdata_d;
      dtack_n_q  <= dtack_n_d;
      vpa_n_q    <= vpa_n_d;
      berr_q     <= berr_d;
      tmo_q      <= tmo_d;
      wait_q     <= wait_d;
      req_sent_q <= req_sent_d;
    end
  end

  // NOTE: address/data holding registers need no reset; they are only consumed qualified by mem_req.
  always_ff @(posedge clk) begin
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
  end

  assign rdata     = rdata_q;
  assign dtack_n   = dtack_n_q;
  assign vpa_n     = vpa_n_q;
  assign berr      = berr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/m68k_bus_target.md
Name: m68k_bus_target

Overview:
- Responder end of the 68000-style asynchronous bus driven by the TG68K bus wrapper.
- Decodes AS/UDS/LDS/RW/FC cycles and bridges them to a single-outstanding synchronous backend (RAM/registers).
- Returns DTACK, or the VPA/VMA/E-synchronous handshake for 6800-type peripherals, plus interrupt-acknowledge vectors and a bus-error timeout.
- Sits between the CPU wrapper and the address decoder/memory controller.

Parameters:
- WAIT_STATES, 1, number of phi2 enables between backend ack and DTACK assertion (0..15).
- BERR_TIMEOUT, 255, clk cycles from cycle start with no DTACK/VPA before BERR asserts (8-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- phi1  in  1  CPU phase-1 clock enable
- phi2  in  1  CPU phase-2 clock enable
- as_n  in  1  address strobe
- rw_n  in  1  1=read, 0=write
- uds_n  in  1  upper data strobe
- lds_n  in  1  lower data strobe
- fc  in  3  function code
- addr  in  23  word address A23..A1
- wdata  in  16  CPU write data
- rdata  out  16  data to CPU
- dtack_n  out  1  data acknowledge
- vpa_n  out  1  valid peripheral address
- berr  out  1  bus error
- vma_n  in  1  valid memory address from CPU
- e_negclken  in  1  E falling-edge enable
- periph_sel  in  1  decoder: address is a 6800-type peripheral
- iack_auto  in  1  interrupt source wants an autovector
- iack_vector  in  8  vector number for vectored IACK
- mem_req  out  1  one-clk backend request
- mem_we  out  1  backend write
- mem_be  out  2  byte enables {upper, lower}
- mem_addr  out  23  latched address
- mem_wdata  out  16  latched write data
- mem_rdata  in  16  backend read data
- mem_ack  in  1  backend done; may be the cycle after mem_req at the earliest

Behaviour:
- Reset values: dtack_n=1, vpa_n=1, berr=0, mem_req=0, mem_we=0, mem_be=0, rdata=0; state IDLE, counters 0. Reset mid-cycle abandons the transaction; a later mem_ack is ignored.
- All inputs are sampled on clk. State changes are gated by phi1/phi2 only where stated.
- States:
  - IDLE, START, MEM_WAIT, DELAY, ACK: memory path.
  - VPA_WAIT, VPA_E: 6800-peripheral path.
  - IACK: interrupt acknowledge.
  - ERR: bus error.
- IDLE -> START when as_n=0. Latch addr, fc and rw_n. Clear the timeout counter.
- START → branch (all branches require, for writes, uds_n=0 or lds_n=0 first):
  - fc=3'b111 → IACK.
  - periph_sel=1 → VPA_WAIT.
  - otherwise → MEM_WAIT: pulse mem_req for exactly 1 clk, with mem_we=~rw_n, mem_be={~uds_n,~lds_n}, mem_wdata=wdata.
- MEM_WAIT → DELAY on mem_ack. Reads latch rdata<=mem_rdata. DELAY counts WAIT_STATES phi2 enables (0 means go immediately) → ACK.
- ACK: on the next phi2, dtack_n<=0. Hold until as_n=1, then dtack_n<=1 and go to IDLE (same clk as as_n sampled high).
- IACK:
  - iack_auto=1: vpa_n<=0.
  - else: rdata<={8'h00,iack_vector}, then dtack_n<=0 on the next phi2.
  - Both release on as_n=1.
- VPA_WAIT:
  - vpa_n<=0 on the next phi2.
  - When vma_n=0, issue mem_req as above. Latch mem_rdata on mem_ack, then go to VPA_E.
  - VPA_E: hold vpa_n=0 (CPU terminates its cycle off E); release on as_n=1.
  - If e_negclken fires before mem_ack, the read data is stale. This is a decoder error; the block still completes the cycle.
- Timeout:
  - Counter increments every clk in any state other than IDLE/ACK/VPA_E and IACK-after-assert.
  - Reaching BERR_TIMEOUT → ERR: berr=1 until as_n=1.
  - A mem_ack arriving in ERR is dropped; dtack_n stays 1.
- Early as_n=1 (abort) in any non-IDLE state: all outputs return to idle values the next clk; a pending mem_ack is ignored.
- Back-to-back: a new cycle may start on the clk after return to IDLE. as_n must be observed high for at least 1 clk between cycles.
- rdata holds its value until the next read latch.

Test Plan:
- Word read, WAIT_STATES=1, addr=23'h000100: mem_rdata=16'hBEEF with ack 3 clk after req → one mem_req pulse, mem_be=2'b11, dtack_n low on 2nd phi2 after ack, rdata=16'hBEEF, dtack_n high 1 clk after as_n rises.
- Byte write, uds_n=1/lds_n=0, wdata=16'h0012: strobe asserted 2 phi after as_n → mem_req only after lds_n low, mem_we=1, mem_be=2'b01, mem_wdata=16'h0012.
- IACK fc=3'b111: iack_auto=0, vector 8'h40 → rdata=16'h0040, dtack_n=0; repeat with iack_auto=1 → vpa_n=0, dtack_n stays 1.
- Peripheral read, periph_sel=1: vma_n low after 6 phi2 → vpa_n low first, mem_req only after vma_n=0, vpa_n held until as_n high, dtack_n never asserts.
- No mem_ack, BERR_TIMEOUT=255 → berr=1 exactly 255 clk after cycle start. Late mem_ack produces no dtack; berr clears when as_n rises.
- Reset asserted during MEM_WAIT; as_n aborted during DELAY → all outputs idle next clk, no dtack, subsequent read completes normally.
